// File: rtl/dac_driver_pkg.sv
// Shared constants and state encoding for the DAC8564-class serial driver.
package dac_driver_pkg;

  localparam int FRAME_BITS = 24;
  localparam int HDR_W      = 8;
  localparam int DATA_W     = 16;

  localparam logic [HDR_W-1:0] HDR_CH_A = 8'h10;
  localparam logic [HDR_W-1:0] HDR_CH_B = 8'h12;
  localparam logic [HDR_W-1:0] HDR_CH_C = 8'h14;
  localparam logic [HDR_W-1:0] HDR_CH_D = 8'h16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/dac_driver.sv
// Shifts a captured {header, value} word MSB-first to a 24-bit SPI-style DAC,
// generating clk_out and an active-low sync; one request can wait behind a frame.
module dac_driver
  import dac_driver_pkg::*;
#(
  parameter int SCLK_HALF  = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              sync,
  output logic              din,
  output logic              clk_out,
  input  logic [HDR_W-1:0]  header,
  input  logic [DATA_W-1:0] value,
  input  logic              trigger
);

  localparam int PH_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int GP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCLK_HALF - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYCLES - 1);

  state_t                r_state, w_state_next;
  logic                  r_trig_q;
  logic                  r_armed;
  logic                  r_pending, w_pending_next;
  // Bit 23 goes straight to din at load, so only the remaining 23 bits are held.
  logic [FRAME_BITS-2:0] r_shreg, w_shreg_next;
  logic [4:0]            r_bit, w_bit_next;
  logic [PH_W-1:0]       r_phase, w_phase_next;
  logic                  r_low, w_low_next;
  logic [GP_W-1:0]       r_gap, w_gap_next;
  logic                  r_sync, w_sync_next;
  logic                  r_clk_out, w_clk_out_next;
  logic                  r_din, w_din_next;
  logic                  w_req;

  // r_armed blocks a trigger that was already high when reset released.
  assign w_req = trigger & ~r_trig_q & r_armed;

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_shreg_next   = r_shreg;
    w_bit_next     = r_bit;
    w_phase_next   = r_phase;
    w_low_next     = r_low;
    w_gap_next     = r_gap;
    w_sync_next    = r_sync;
    w_clk_out_next = r_clk_out;
    w_din_next     = r_din;
    case (r_state)
      IDLE: begin
        w_sync_next    = 1'b1;
        w_clk_out_next = 1'b1;
        w_din_next     = 1'b0;
        if (w_req || r_pending) begin
          w_shreg_next   = {header[HDR_W-2:0], value};
          w_pending_next = 1'b0;
          w_bit_next     = 5'(FRAME_BITS - 1);
          w_phase_next   = '0;
          w_low_next     = 1'b0;
          w_state_next   = SHIFT;
          w_sync_next    = 1'b0;
          w_din_next     = header[HDR_W-1];
        end
      end
      SHIFT: begin
        if (w_req) w_pending_next = 1'b1;
        if (r_phase == PH_LAST) begin
          w_phase_next = '0;
          if (!r_low) begin
            w_low_next     = 1'b1;
            w_clk_out_next = 1'b0;
          end else if (r_bit == 5'd0) begin
            // Rising clk_out and sync leave together, after the last falling edge.
            w_state_next   = GAP;
            w_gap_next     = '0;
            w_low_next     = 1'b0;
            w_sync_next    = 1'b1;
            w_clk_out_next = 1'b1;
            w_din_next     = 1'b0;
          end else begin
            w_low_next     = 1'b0;
            w_bit_next     = r_bit - 5'd1;
            w_clk_out_next = 1'b1;
            w_din_next     = r_shreg[FRAME_BITS-2];
            w_shreg_next   = {r_shreg[FRAME_BITS-3:0], 1'b0};
          end
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end
      end
      GAP: begin
        if (w_req) w_pending_next = 1'b1;
        if (r_gap == GP_LAST) w_state_next = IDLE;
        else                  w_gap_next   = r_gap + GP_W'(1);
      end
      default: begin
        w_state_next   = IDLE;
        w_sync_next    = 1'b1;
        w_clk_out_next = 1'b1;
        w_din_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_trig_q  <= 1'b0;
      r_armed   <= 1'b0;
      r_pending <= 1'b0;
      r_shreg   <= '0;
      r_bit     <= '0;
      r_phase   <= '0;
      r_low     <= 1'b0;
      r_gap     <= '0;
      r_sync    <= 1'b1;
      r_clk_out <= 1'b1;
      r_din     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_trig_q  <= trigger;
      r_armed   <= r_armed | ~trigger;
      r_pending <= w_pending_next;
      r_shreg   <= w_shreg_next;
      r_bit     <= w_bit_next;
      r_phase   <= w_phase_next;
      r_low     <= w_low_next;
      r_gap     <= w_gap_next;
      r_sync    <= w_sync_next;
      r_clk_out <= w_clk_out_next;
      r_din     <= w_din_next;
    end
  end

  assign sync    = r_sync;
  assign clk_out = r_clk_out;
  assign din     = r_din;

endmodule

// File: tb/tb_dac_driver.sv
// Directed bench: two drivers (SCLK_HALF=1 and 3) with a per-driver scoreboard
// of expected 24-bit words, decoded from din on each clk_out falling edge.
module tb_dac_driver;
  import dac_driver_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hdr0, hdr1;
  logic [15:0] val0, val1;
  logic        trg0, trg1;
  logic        sync0, din0, sclk0;
  logic        sync1, din1, sclk1;

  always #5 clk = ~clk;

  dac_driver #(.SCLK_HALF(1), .GAP_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .sync(sync0), .din(din0), .clk_out(sclk0),
    .header(hdr0), .value(val0), .trigger(trg0)
  );

  dac_driver #(.SCLK_HALF(3), .GAP_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .sync(sync1), .din(din1), .clk_out(sclk1),
    .header(hdr1), .value(val1), .trigger(trg1)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic        prev_sync [2];
  logic        prev_clk  [2];
  logic [23:0] word      [2];
  int          nbits     [2];
  int          low_cnt   [2];
  int          run       [2];
  int          high_cnt  [2];
  bit          had_frame [2];
  int          frames    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame decoder for one driver, called once per cycle at the falling clk edge.
  task automatic mon(input int i, input logic s, input logic c, input logic d, input int half);
    logic [23:0] e;
    bit          have;
    if (rst) begin
      nbits[i] = 0; word[i] = '0; low_cnt[i] = 0; run[i] = 0;
      high_cnt[i] = 0; had_frame[i] = 1'b0;
    end else if (!s) begin
      if (prev_sync[i]) begin
        if (had_frame[i]) chk($sformatf("gap_dut%0d", i), 32'(high_cnt[i] >= 2), 32'd1);
        nbits[i] = 0; word[i] = '0; low_cnt[i] = 1; run[i] = 1;
      end else begin
        low_cnt[i]++;
        if (c != prev_clk[i]) begin
          chk($sformatf("phase_len_dut%0d", i), 32'(run[i]), 32'(half));
          run[i] = 1;
          if (!c) begin
            word[i] = {word[i][22:0], d};
            nbits[i]++;
          end
        end else begin
          run[i]++;
        end
      end
    end else begin
      if (!prev_sync[i]) begin
        chk($sformatf("last_phase_dut%0d", i), 32'(run[i]), 32'(half));
        chk($sformatf("nbits_dut%0d", i), 32'(nbits[i]), 32'd24);
        chk($sformatf("sync_low_dut%0d", i), 32'(low_cnt[i]), 32'(48 * half));
        have = 1'b0;
        e = '0;
        if (i == 0 && q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
        chk($sformatf("frame_expected_dut%0d", i), 32'(have), 32'd1);
        if (have) chk($sformatf("word_dut%0d", i), 32'(word[i]), 32'(e));
        $display("frame dut%0d word=%06h expected=%06h", i, word[i], e);
        frames[i]++;
        had_frame[i] = 1'b1;
        high_cnt[i] = 1;
      end else begin
        high_cnt[i]++;
      end
    end
    prev_sync[i] = s;
    prev_clk[i]  = c;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon(0, sync0, sclk0, din0, 1);
    mon(1, sync1, sclk1, din1, 3);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic pulse0();
    trg0 = 1'b1; cyc(); trg0 = 1'b0; cyc();
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      cyc();
    end
    chk("timeout_q0", 32'(q0.size()), 32'd0);
    chk("timeout_q1", 32'(q1.size()), 32'd0);
    cycles(5);
  endtask

  initial begin
    int          f0;
    logic [15:0] vals [3];
    vals[0] = 16'h8000; vals[1] = 16'h8C8B; vals[2] = 16'h98F8;
    for (int i = 0; i < 2; i++) begin
      prev_sync[i] = 1'b1; prev_clk[i] = 1'b1; word[i] = '0; nbits[i] = 0;
      low_cnt[i] = 0; run[i] = 0; high_cnt[i] = 0; had_frame[i] = 1'b0; frames[i] = 0;
    end
    rst = 1'b1; trg0 = 1'b0; trg1 = 1'b0;
    hdr0 = '0; val0 = '0; hdr1 = '0; val1 = '0;
    cycles(3);
    chk("reset_dut0", 32'({sync0, sclk0, din0}), 32'b110);
    chk("reset_dut1", 32'({sync1, sclk1, din1}), 32'b110);
    rst = 1'b0;

    // Quiet period: outputs must hold their idle values.
    for (int k = 0; k < 100; k++) begin
      cyc();
      chk("idle_dut0", 32'({sync0, sclk0, din0}), 32'b110);
      chk("idle_dut1", 32'({sync1, sclk1, din1}), 32'b110);
    end

    // Single frame, also checking first-bit latency.
    hdr0 = HDR_CH_D; val0 = 16'h8000; q0.push_back({HDR_CH_D, 16'h8000});
    trg0 = 1'b1; cyc();
    chk("first_cycle_dut0", 32'({sync0, sclk0, din0}), 32'b010);
    trg0 = 1'b0;
    wait_done(200);

    // Value change mid-frame must not leak into the frame in flight.
    hdr0 = HDR_CH_A; val0 = 16'hFFFF; q0.push_back({HDR_CH_A, 16'hFFFF});
    pulse0();
    cycles(10);
    val0 = 16'h0000;
    wait_done(200);

    // Trigger period 42: each request queues behind the frame in progress.
    hdr0 = HDR_CH_B;
    for (int k = 0; k < 3; k++) begin
      val0 = vals[k];
      q0.push_back({HDR_CH_B, vals[k]});
      trg0 = 1'b1; cycles(21);
      trg0 = 1'b0; cycles(21);
    end
    wait_done(400);

    // Three fast requests: second pends (loads the value present at load), third drops.
    f0 = frames[0];
    hdr0 = HDR_CH_A; val0 = 16'h1111; q0.push_back({HDR_CH_A, 16'h1111});
    pulse0(); cycles(8);
    val0 = 16'h2222;
    pulse0(); cycles(8);
    val0 = 16'h3333; q0.push_back({HDR_CH_A, 16'h3333});
    pulse0();
    wait_done(300);
    cycles(80);
    chk("drop_frames_dut0", 32'(frames[0] - f0), 32'd2);
    chk("drop_queue_dut0", 32'(q0.size()), 32'd0);

    // Reset around bit 10 with a request pending: frame abandoned, pending cleared.
    hdr0 = HDR_CH_C; val0 = 16'h5A5A; q0.push_back({HDR_CH_C, 16'h5A5A});
    pulse0(); cycles(4);
    pulse0(); cycles(19);
    chk("mid_frame_busy_dut0", 32'(sync0), 32'd0);
    rst = 1'b1;
    #1;
    chk("reset_mid_dut0", 32'({sync0, sclk0, din0}), 32'b110);
    q0.delete();
    cycles(2);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      chk("no_pending_after_rst_dut0", 32'(sync0), 32'd1);
    end
    hdr0 = HDR_CH_D; val0 = 16'h1234; q0.push_back({HDR_CH_D, 16'h1234});
    pulse0();
    wait_done(200);

    // Slow serial clock: 3-cycle phases, 144-cycle frame.
    hdr1 = HDR_CH_B; val1 = 16'hA527; q1.push_back({HDR_CH_B, 16'hA527});
    trg1 = 1'b1; cyc(); trg1 = 1'b0;
    wait_done(400);
    chk("frames_dut1", 32'(frames[1]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
